icache_refill_ctrl: RTL and testbench

- Instruction-cache refill engine sitting directly upstream of the pipeline datapath.
- On an I-cache miss it takes the datapath's miss address and issues one AXI4 INCR read burst.
- It assembles the returned beats into one cache block and drives the datapath's instruction-block write inputs (block data plus one-cycle write enable).
- It tells the hazard logic a refill is in progress so fetch is stalled.

---
 rtl/icache_refill_ctrl.sv | 129 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// I-cache refill engine: one AXI4 INCR read burst per miss, beats assembled into a cache block
// and written to the datapath with a single-cycle strobe. Fetch is stalled while a refill runs.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned BLOCK_WIDTH    = 512,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]     i_miss_addr,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
  output logic [7:0]                o_axi_arlen,
  output logic [2:0]                o_axi_arsize,
  output logic [1:0]                o_axi_arburst,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rlast,
  output logic [BLOCK_WIDTH-1:0]    o_instr_block,
  output logic                      o_instr_we,
  output logic                      o_refill_busy,
  output logic                      o_bus_error
);

  localparam int unsigned BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OffW  = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CntW-1:0]       LastCnt = CntW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OffMask = (ADDR_WIDTH'(1) << OffW) - ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StGuard
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0]  block_q, block_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    bus_error_q, bus_error_d;
  logic                    burst_err_q, burst_err_d;
  logic                    beat_err;

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      block_q     <= '0;
      araddr_q    <= '0;
      bus_error_q <= 1'b0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      araddr_q    <= araddr_d;
      bus_error_q <= bus_error_d;
      burst_err_q <= burst_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    araddr_d    = araddr_q;
    bus_error_d = bus_error_q;
    burst_err_d = burst_err_q;
    beat_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!i_icache_hit) begin
          araddr_d = i_miss_addr & ~OffMask;
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (i_axi_arready) begin
          cnt_d       = '0;
          burst_err_d = 1'b0;
          state_d     = StData;
        end
      end
      StData: begin
        if (i_axi_rvalid) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CntW'(b)) begin
              block_d[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_axi_rdata;
            end
          end
          // rlast must coincide exactly with the final counted beat; the counter ends the burst.
          beat_err    = (i_axi_rresp != 2'b00) |
                        ((cnt_q == LastCnt) ? ~i_axi_rlast : i_axi_rlast);
          bus_error_d = bus_error_q | beat_err;
          burst_err_d = burst_err_q | beat_err;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = (burst_err_q | beat_err) ? StGuard : StWrite;
          end
        end
      end
      StWrite: state_d = StGuard;
      // Lets the tag/hit update before the miss is looked at again.
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign o_axi_arvalid = (state_q == StAddr);
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arlen   = 8'(BEATS - 1);
  assign o_axi_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_axi_arburst = 2'b01;
  assign o_axi_rready  = (state_q == StData);
  assign o_instr_block = block_q;
  assign o_instr_we    = (state_q == StWrite);
  // Combinational on the hit so the miss cycle itself already stalls fetch.
  assign o_refill_busy = (state_q != StIdle) | ~i_icache_hit;
  assign o_bus_error   = bus_error_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl against a burst-level reference model.
module tb_icache_refill_ctrl;

  logic         i_clk, i_arst, i_icache_hit;
  logic [63:0]  i_miss_addr;
  logic         o_axi_arvalid, i_axi_arready;
  logic [63:0]  o_axi_araddr;
  logic [7:0]   o_axi_arlen;
  logic [2:0]   o_axi_arsize;
  logic [1:0]   o_axi_arburst;
  logic         i_axi_rvalid, o_axi_rready;
  logic [63:0]  i_axi_rdata;
  logic [1:0]   i_axi_rresp;
  logic         i_axi_rlast;
  logic [511:0] o_instr_block;
  logic         o_instr_we, o_refill_busy, o_bus_error;

  icache_refill_ctrl dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_icache_hit  (i_icache_hit),
    .i_miss_addr   (i_miss_addr),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .o_axi_araddr  (o_axi_araddr),
    .o_axi_arlen   (o_axi_arlen),
    .o_axi_arsize  (o_axi_arsize),
    .o_axi_arburst (o_axi_arburst),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp),
    .i_axi_rlast   (i_axi_rlast),
    .o_instr_block (o_instr_block),
    .o_instr_we    (o_instr_we),
    .o_refill_busy (o_refill_busy),
    .o_bus_error   (o_bus_error)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_pass = 0;
  int n_total = 0;
  logic exp_sticky = 1'b0;

  // Slave-side beat script for the next burst
  logic [63:0] beat_data [8];
  logic [1:0]  beat_resp [8];
  logic        beat_last [8];

  // Observations collected by the driver
  int           obs_ar_first, obs_ar_cnt, obs_we_cnt, obs_we_cycle, obs_idle, obs_last, obs_beats;
  bit           obs_ar_stable, obs_busy_ok, obs_timeout;
  logic [63:0]  obs_araddr;
  logic [511:0] obs_block;
  logic         obs_err_pre;

  function automatic logic [511:0] model_block();
    return {beat_data[7], beat_data[6], beat_data[5], beat_data[4],
            beat_data[3], beat_data[2], beat_data[1], beat_data[0]};
  endfunction

  function automatic logic model_err();
    logic e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (beat_resp[i] != 2'b00) e = 1'b1;
      if (i < 7 && beat_last[i]) e = 1'b1;
    end
    if (!beat_last[7]) e = 1'b1;
    return e;
  endfunction

  task automatic clean_beats(input bit counting);
    for (int i = 0; i < 8; i++) begin
      beat_data[i] = counting ? 64'h1111_1111_1111_1111 * 64'(i + 1) : {$urandom, $urandom};
      beat_resp[i] = 2'b00;
      beat_last[i] = (i == 7);
    end
  endtask

  task automatic drive_garbage();
    i_axi_rvalid = 1'($urandom_range(0, 1));
    i_axi_rdata  = {$urandom, $urandom};
    i_axi_rresp  = 2'($urandom_range(0, 3));
    i_axi_rlast  = 1'($urandom_range(0, 1));
  endtask

  // Called just after a negedge with the DUT idle; that cycle is cycle 0 (the miss).
  task automatic do_burst(input logic [63:0] addr, input int ar_wait, input int gap_mode,
                          input int abort_at);
    int c, k, ar_seen;
    bit done, alt, give;
    c = 0; k = 0; ar_seen = 0; done = 0; alt = 0;
    obs_ar_first = -1; obs_ar_cnt = 0; obs_ar_stable = 1; obs_araddr = '0;
    obs_we_cnt = 0; obs_we_cycle = -1; obs_block = '0; obs_busy_ok = 1;
    obs_idle = -1; obs_last = -1; obs_timeout = 0; obs_beats = 0; obs_err_pre = 1'b0;
    i_icache_hit = 1'b0; i_miss_addr = addr; i_axi_arready = 1'b0; drive_garbage();
    #1;
    if (o_refill_busy !== 1'b1) obs_busy_ok = 0;
    while (!done && c < 200) begin
      @(negedge i_clk); c++;
      if (o_instr_we === 1'b1) begin
        obs_we_cnt++;
        if (obs_we_cnt == 1) begin obs_we_cycle = c; obs_block = o_instr_block; end
      end
      if (o_axi_arvalid === 1'b1) begin
        if (ar_seen == 0) begin obs_ar_first = c; obs_araddr = o_axi_araddr; end
        else if (o_axi_araddr !== obs_araddr) obs_ar_stable = 0;
        ar_seen++; obs_ar_cnt = ar_seen;
        i_axi_arready = (ar_seen == ar_wait + 1);
      end else begin
        i_axi_arready = 1'($urandom_range(0, 1));
      end
      i_miss_addr = {$urandom, $urandom};
      if (o_axi_rready === 1'b1) begin
        alt = ~alt;
        give = (gap_mode == 0) || (gap_mode == 1 && !alt) ||
               (gap_mode == 2 && $urandom_range(0, 1) == 1);
        if (k < 8 && give) begin
          i_axi_rvalid = 1'b1; i_axi_rdata = beat_data[k];
          i_axi_rresp = beat_resp[k]; i_axi_rlast = beat_last[k];
          k++;
          if (k == 8) obs_last = c;
        end else begin
          i_axi_rvalid = 1'b0; i_axi_rdata = {$urandom, $urandom};
        end
      end else begin
        drive_garbage();
      end
      i_icache_hit = (k == 8) ? 1'b1 : 1'($urandom_range(0, 1));
      if (abort_at >= 0 && k == abort_at + 1) begin
        obs_err_pre = o_bus_error;
        #2 i_arst = 1'b0;
        done = 1;
      end else begin
        #1;
        if (k == 8 && c > obs_last && o_refill_busy === 1'b0) begin
          obs_idle = c; done = 1;
        end else if (o_refill_busy !== 1'b1) begin
          obs_busy_ok = 0;
        end
      end
    end
    obs_beats = k;
    if (!done) obs_timeout = 1;
  endtask

  task automatic test_reset();
    i_icache_hit = 1'b1;
    #1;
    n_total++; if (o_axi_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", o_axi_arvalid); else n_pass++;
    n_total++; if (o_axi_rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", o_axi_rready); else n_pass++;
    n_total++; if (o_instr_we !== 1'b0) $display("FAIL rst_we: got %b want 0", o_instr_we); else n_pass++;
    n_total++; if (o_bus_error !== 1'b0) $display("FAIL rst_err: got %b want 0", o_bus_error); else n_pass++;
    n_total++; if (o_axi_araddr !== 64'h0) $display("FAIL rst_araddr: got %h want 0", o_axi_araddr); else n_pass++;
    n_total++; if (o_instr_block !== 512'h0) $display("FAIL rst_block: got %h want 0", o_instr_block); else n_pass++;
    n_total++; if (o_refill_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_refill_busy); else n_pass++;
    n_total++; if (o_axi_arlen !== 8'd7) $display("FAIL arlen: got %0d want 7", o_axi_arlen); else n_pass++;
    n_total++; if (o_axi_arsize !== 3'd3) $display("FAIL arsize: got %0d want 3", o_axi_arsize); else n_pass++;
    n_total++; if (o_axi_arburst !== 2'd1) $display("FAIL arburst: got %0d want 1", o_axi_arburst); else n_pass++;
  endtask

  task automatic test_zero_wait();
    clean_beats(1);
    do_burst(64'h8000_0044, 0, 0, -1);
    exp_sticky = exp_sticky | model_err();
    n_total++; if (obs_araddr !== 64'h8000_0040) $display("FAIL zw_araddr: got %h want 8000_0040", obs_araddr); else n_pass++;
    n_total++; if (obs_ar_first !== 1) $display("FAIL zw_ar_cycle: got %0d want 1", obs_ar_first); else n_pass++;
    n_total++; if (obs_we_cnt !== 1) $display("FAIL zw_we_cnt: got %0d want 1", obs_we_cnt); else n_pass++;
    n_total++; if (obs_we_cycle !== 10) $display("FAIL zw_we_cycle: got %0d want 10", obs_we_cycle); else n_pass++;
    n_total++; if (obs_block[63:0] !== 64'h1111_1111_1111_1111) $display("FAIL zw_beat0: got %h want 1111..1", obs_block[63:0]); else n_pass++;
    n_total++; if (obs_block[511:448] !== 64'h8888_8888_8888_8888) $display("FAIL zw_beat7: got %h want 8888..8", obs_block[511:448]); else n_pass++;
    n_total++; if (obs_block !== model_block()) $display("FAIL zw_block: got %h want %h", obs_block, model_block()); else n_pass++;
    n_total++; if (obs_idle !== 12) $display("FAIL zw_idle_cycle: got %0d want 12", obs_idle); else n_pass++;
    n_total++; if (obs_busy_ok !== 1) $display("FAIL zw_busy: got %0d want 1", obs_busy_ok); else n_pass++;
    n_total++; if (o_bus_error !== exp_sticky) $display("FAIL zw_err: got %b want %b", o_bus_error, exp_sticky); else n_pass++;
  endtask

  task automatic test_ar_stall();
    logic [63:0] a = {$urandom, $urandom};
    clean_beats(0);
    do_burst(a, 5, 0, -1);
    n_total++; if (obs_ar_cnt !== 6) $display("FAIL ars_ar_cycles: got %0d want 6", obs_ar_cnt); else n_pass++;
    n_total++; if (obs_ar_stable !== 1) $display("FAIL ars_stable: got %0d want 1", obs_ar_stable); else n_pass++;
    n_total++; if (obs_araddr !== (a & ~64'h3F)) $display("FAIL ars_araddr: got %h want %h", obs_araddr, a & ~64'h3F); else n_pass++;
    n_total++; if (obs_we_cycle !== 15) $display("FAIL ars_we_cycle: got %0d want 15", obs_we_cycle); else n_pass++;
    n_total++; if (obs_block !== model_block()) $display("FAIL ars_block: got %h want %h", obs_block, model_block()); else n_pass++;
  endtask

  task automatic test_rvalid_gaps();
    clean_beats(0);
    do_burst({$urandom, $urandom}, 0, 1, -1);
    n_total++; if (obs_block !== model_block()) $display("FAIL gap_block: got %h want %h", obs_block, model_block()); else n_pass++;
    n_total++; if (obs_we_cnt !== 1) $display("FAIL gap_we_cnt: got %0d want 1", obs_we_cnt); else n_pass++;
    n_total++; if (obs_we_cycle !== 18) $display("FAIL gap_we_cycle: got %0d want 18", obs_we_cycle); else n_pass++;
    n_total++; if (obs_busy_ok !== 1) $display("FAIL gap_busy: got %0d want 1", obs_busy_ok); else n_pass++;
    n_total++; if (obs_idle !== 20) $display("FAIL gap_idle_cycle: got %0d want 20", obs_idle); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [63:0] a;
      int aw, gm;
      logic e;
      a = {$urandom, $urandom}; aw = $urandom_range(0, 3); gm = $urandom_range(0, 2);
      clean_beats(0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: beat_resp[$urandom_range(0, 7)] = 2'($urandom_range(1, 3));
          1: beat_last[$urandom_range(0, 6)] = 1'b1;
          default: beat_last[7] = 1'b0;
        endcase
      end
      e = model_err();
      exp_sticky = exp_sticky | e;
      do_burst(a, aw, gm, -1);
      n_total++; if (obs_araddr !== (a & ~64'h3F)) $display("FAIL rnd_araddr[%0d]: got %h want %h", it, obs_araddr, a & ~64'h3F); else n_pass++;
      n_total++; if (obs_ar_cnt !== aw + 1) $display("FAIL rnd_ar_cycles[%0d]: got %0d want %0d", it, obs_ar_cnt, aw + 1); else n_pass++;
      n_total++; if (obs_we_cnt !== (e ? 0 : 1)) $display("FAIL rnd_we_cnt[%0d]: got %0d want %0d", it, obs_we_cnt, e ? 0 : 1); else n_pass++;
      if (!e) begin
        n_total++; if (obs_block !== model_block()) $display("FAIL rnd_block[%0d]: got %h want %h", it, obs_block, model_block()); else n_pass++;
      end
      n_total++; if (obs_idle !== obs_last + (e ? 2 : 3)) $display("FAIL rnd_idle[%0d]: got %0d want %0d", it, obs_idle, obs_last + (e ? 2 : 3)); else n_pass++;
      n_total++; if (o_bus_error !== exp_sticky) $display("FAIL rnd_err[%0d]: got %b want %b", it, o_bus_error, exp_sticky); else n_pass++;
      n_total++; if (obs_timeout !== 0) $display("FAIL rnd_timeout[%0d]: got %0d want 0", it, obs_timeout); else n_pass++;
    end
  endtask

  task automatic test_rresp_error();
    clean_beats(0);
    beat_resp[3] = 2'b10;
    do_burst({$urandom, $urandom}, 0, 0, -1);
    exp_sticky = 1'b1;
    n_total++; if (o_bus_error !== 1'b1) $display("FAIL resp_err: got %b want 1", o_bus_error); else n_pass++;
    n_total++; if (obs_we_cnt !== 0) $display("FAIL resp_we_cnt: got %0d want 0", obs_we_cnt); else n_pass++;
    n_total++; if (obs_idle !== 11) $display("FAIL resp_idle_cycle: got %0d want 11", obs_idle); else n_pass++;
    clean_beats(0);
    do_burst({$urandom, $urandom}, 0, 0, -1);
    n_total++; if (obs_ar_first !== 1) $display("FAIL retry_ar_cycle: got %0d want 1", obs_ar_first); else n_pass++;
    n_total++; if (obs_block !== model_block()) $display("FAIL retry_block: got %h want %h", obs_block, model_block()); else n_pass++;
    n_total++; if (obs_we_cnt !== 1) $display("FAIL retry_we_cnt: got %0d want 1", obs_we_cnt); else n_pass++;
    n_total++; if (o_bus_error !== 1'b1) $display("FAIL retry_err_sticky: got %b want 1", o_bus_error); else n_pass++;
  endtask

  task automatic test_rlast_early();
    clean_beats(0);
    beat_last[5] = 1'b1;
    do_burst({$urandom, $urandom}, 0, 0, -1);
    n_total++; if (o_bus_error !== 1'b1) $display("FAIL rlast_err: got %b want 1", o_bus_error); else n_pass++;
    n_total++; if (obs_we_cnt !== 0) $display("FAIL rlast_we_cnt: got %0d want 0", obs_we_cnt); else n_pass++;
    n_total++; if (obs_beats !== 8) $display("FAIL rlast_beats: got %0d want 8", obs_beats); else n_pass++;
    n_total++; if (obs_idle !== 11) $display("FAIL rlast_idle_cycle: got %0d want 11", obs_idle); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] a = {$urandom, $urandom};
    clean_beats(0);
    beat_resp[1] = 2'b01;
    do_burst(a, 0, 0, 4);
    #1;
    n_total++; if (obs_err_pre !== 1'b1) $display("FAIL mid_err_before: got %b want 1", obs_err_pre); else n_pass++;
    n_total++; if (o_axi_rready !== 1'b0) $display("FAIL mid_rready: got %b want 0", o_axi_rready); else n_pass++;
    n_total++; if (o_bus_error !== 1'b0) $display("FAIL mid_err: got %b want 0", o_bus_error); else n_pass++;
    n_total++; if (o_axi_araddr !== 64'h0) $display("FAIL mid_araddr: got %h want 0", o_axi_araddr); else n_pass++;
    n_total++; if (o_instr_block !== 512'h0) $display("FAIL mid_block: got %h want 0", o_instr_block); else n_pass++;
    exp_sticky = 1'b0;
    @(negedge i_clk);
    i_arst = 1'b1; i_icache_hit = 1'b1; i_axi_rvalid = 1'b0;
    @(negedge i_clk);
    #1;
    n_total++; if (o_refill_busy !== 1'b0) $display("FAIL mid_idle_busy: got %b want 0", o_refill_busy); else n_pass++;
    n_total++; if (o_instr_we !== 1'b0) $display("FAIL mid_we: got %b want 0", o_instr_we); else n_pass++;
    clean_beats(0);
    do_burst(a, 0, 0, -1);
    n_total++; if (obs_block !== model_block()) $display("FAIL mid_fresh_block: got %h want %h", obs_block, model_block()); else n_pass++;
    n_total++; if (obs_we_cycle !== 10) $display("FAIL mid_fresh_we_cycle: got %0d want 10", obs_we_cycle); else n_pass++;
    n_total++; if (o_bus_error !== 1'b0) $display("FAIL mid_fresh_err: got %b want 0", o_bus_error); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    i_arst = 1'b0; i_icache_hit = 1'b1; i_miss_addr = '0; i_axi_arready = 1'b0;
    i_axi_rvalid = 1'b0; i_axi_rdata = '0; i_axi_rresp = 2'b00; i_axi_rlast = 1'b0;
    repeat (2) @(negedge i_clk);
    test_reset();
    @(negedge i_clk);
    i_arst = 1'b1;
    @(negedge i_clk);
    test_zero_wait();
    test_ar_stall();
    test_rvalid_gaps();
    test_random();
    test_rresp_error();
    test_rlast_early();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
